// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter sharing one interval countdown timer among N_REQ requesters.
// The owner gets a one-cycle done pulse after len+1 enabled RUN cycles.
module interval_timer_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] ptr_next;
  logic [N_REQ-1:0] grant_d, done_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] len_sel;
  logic [IDX_W-1:0] pick;
  logic             pick_vld;

  // Circular scan for the first live request at or after ptr.
  always_comb begin
    int unsigned      idx;
    logic [IDX_W-1:0] sel_i;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    sel_i    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx   = (32'(ptr_q) + k) % N_REQ;
      sel_i = IDX_W'(idx);
      if (!pick_vld && req[sel_i]) begin
        pick_vld = 1'b1;
        pick     = sel_i;
      end
    end
  end

  // Interval of the requester about to be granted.
  always_comb begin
    len_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick == IDX_W'(i)) len_sel = len[i*CNT_W +: CNT_W];
    end
  end

  assign ptr_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant;
    done_d  = '0;
    cnt_d   = cnt;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          grant_d = N_REQ'(1) << pick;
          cnt_d   = len_sel;
          state_d = RUN;
        end
      end
      RUN: begin
        // A dropped owner request aborts silently, even while frozen.
        if (!req[owner_q]) begin
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end else if (en) begin
          if (cnt == '0) begin
            done_d  = grant;
            state_d = DONE;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
      end
      DONE: begin
        grant_d = '0;
        ptr_d   = ptr_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant   <= grant_d;
      done    <= done_d;
      busy    <= (state_d != IDLE);
      cnt     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Scoreboard bench for interval_timer_arbiter (N_REQ=4, CNT_W=8): expected grant/done
// events are queued with their edge number and matched by a negedge monitor.
module tb_interval_timer_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 8;

  logic            clk;
  logic            rst;
  logic            en;
  logic [N-1:0]    req;
  logic [N*CW-1:0] len;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic [CW-1:0]   cnt;

  typedef struct {
    bit           is_done;
    logic [N-1:0] val;
    int           cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  edge_n   = 0;
  int  busy_cnt = 0;
  int  run_cnt  = 0;

  interval_timer_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .len(len),
    .grant(grant), .done(done), .busy(busy), .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit is_done, input logic [N-1:0] val, input int cyc);
    ev_t e;
    e.is_done = is_done;
    e.val     = val;
    e.cyc     = cyc;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req_v, edge_n);
    end
  endtask

  // Observed event vs. head of the scoreboard queue.
  task automatic got(input bit is_done, input logic [N-1:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got %b at edge %0d, nothing expected",
               is_done ? "done" : "grant", val, edge_n);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != is_done || e.val !== val || e.cyc != edge_n) begin
        failures++;
        $display("FAIL event: got %s=%b at edge %0d expected %s=%b at edge %0d",
                 is_done ? "done" : "grant", val, edge_n,
                 e.is_done ? "done" : "grant", e.val, e.cyc);
      end
    end
  endtask

  task automatic monitor();
    logic [N-1:0] pg;
    pg = '0;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && done == '0) run_cnt++;
      if (grant !== pg) begin
        got(1'b0, grant);
        pg = grant;
      end
      if (done !== '0) got(1'b1, done);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    en  = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic set_len(input int i, input logic [CW-1:0] v);
    len[i*CW +: CW] = v;
  endtask

  initial begin
    int e;
    rst = 1'b1;
    en  = 1'b1;
    req = '0;
    len = '0;
    fork
      monitor();
    join_none
    tick(2);
    check("rst_grant", 32'(grant), 0);
    check("rst_done",  32'(done),  0);
    check("rst_busy",  32'(busy),  0);
    check("rst_cnt",   32'(cnt),   0);
    rst = 1'b0;
    tick(1);

    // Single request, len=3.
    set_len(0, 8'd3);
    e = edge_n + 1;
    busy_cnt = 0;
    req = 4'b0001;
    push(0, 4'b0001, e);
    push(1, 4'b0001, e + 4);
    push(0, 4'b0000, e + 5);
    tick(5);
    req = '0;
    tick(3);
    check("busy_cycles_len3", 32'(busy_cnt), 5);

    // All requesting with len=0: rotation 0,1,2,3,0.
    do_reset();
    tick(1);
    len = '0;
    e = edge_n + 1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push(0, 4'(1 << (k % 4)), e + 3*k);
      push(1, 4'(1 << (k % 4)), e + 3*k + 1);
      push(0, 4'b0000,          e + 3*k + 2);
    end
    tick(14);
    req = '0;
    tick(3);

    // Enable dropped for 3 cycles adds 3 cycles to the interval.
    do_reset();
    tick(1);
    set_len(2, 8'd5);
    e = edge_n + 1;
    req = 4'b0100;
    push(0, 4'b0100, e);
    push(1, 4'b0100, e + 9);
    push(0, 4'b0000, e + 10);
    tick(2);
    en = 1'b0;
    tick(3);
    check("cnt_frozen", 32'(cnt), 4);
    en = 1'b1;
    tick(5);
    req = '0;
    tick(3);

    // Abort at cnt==6, then req[3] wins over req[0].
    do_reset();
    tick(1);
    set_len(1, 8'd10);
    set_len(3, 8'd1);
    set_len(0, 8'd0);
    e = edge_n + 1;
    req = 4'b0010;
    push(0, 4'b0010, e);
    push(0, 4'b0000, e + 5);
    push(0, 4'b1000, e + 6);
    push(1, 4'b1000, e + 8);
    push(0, 4'b0000, e + 9);
    push(0, 4'b0001, e + 10);
    push(1, 4'b0001, e + 11);
    push(0, 4'b0000, e + 12);
    tick(1);
    req = 4'b1011;
    tick(4);
    check("cnt_before_abort", 32'(cnt), 6);
    req = 4'b1001;
    tick(4);
    req = 4'b0001;
    tick(3);
    req = '0;
    tick(3);

    // Reset mid-interval with other requests pending.
    do_reset();
    tick(1);
    set_len(0, 8'd55);
    set_len(1, 8'd2);
    e = edge_n + 1;
    req = 4'b0001;
    push(0, 4'b0001, e);
    push(0, 4'b0000, e + 6);
    push(0, 4'b0010, e + 7);
    push(1, 4'b0010, e + 10);
    push(0, 4'b0000, e + 11);
    tick(1);
    req = 4'b1011;
    tick(5);
    check("cnt_mid_run", 32'(cnt), 50);
    rst = 1'b1;
    tick(1);
    check("midrst_grant", 32'(grant), 0);
    check("midrst_done",  32'(done),  0);
    check("midrst_busy",  32'(busy),  0);
    check("midrst_cnt",   32'(cnt),   0);
    rst = 1'b0;
    req = 4'b1010;
    tick(4);
    req = '0;
    tick(3);

    // Maximum interval: 256 RUN cycles, no wrap.
    do_reset();
    tick(1);
    set_len(0, 8'd255);
    e = edge_n + 1;
    run_cnt = 0;
    req = 4'b0001;
    push(0, 4'b0001, e);
    push(1, 4'b0001, e + 256);
    push(0, 4'b0000, e + 257);
    tick(257);
    check("cnt_at_done", 32'(cnt), 0);
    req = '0;
    tick(3);
    check("run_cycles_max", 32'(run_cnt), 256);

    tick(2);
    while (exp_q.size() != 0) begin
      ev_t m;
      m = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event: expected %s=%b at edge %0d never seen",
               m.is_done ? "done" : "grant", m.val, m.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
